hs_slave: RTL and testbench

- Receiving end of the cross-domain valid/ready handshake, living entirely in the clk_2 domain.
- Synchronises the asynchronous valid_2 request from the sending domain and captures data_2 under a 4-phase protocol.
- Returns ready_2 as the acknowledge, buffers received words in a small FIFO, and presents them downstream on a local valid/ready interface.
- Optionally checks that received words form an incrementing sequence.

---
 rtl/hs_slave_if.sv | 22 ++
 rtl/hs_slave.sv | 132 +++++++++++++
 tb/tb_hs_slave.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_slave_if.sv
// Handshake bundle for hs_slave: the cross-domain request/acknowledge pair
// from the sender plus the local show-ahead valid/ready output stream.
interface hs_slave_if #(
    parameter int DATA_W = 8
);
    logic              valid_2;
    logic [DATA_W-1:0] data_2;
    logic              ready_2;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport slave (
        input  valid_2, data_2, out_ready,
        output ready_2, out_valid, out_data
    );

    modport master (
        output valid_2, data_2, out_ready,
        input  ready_2, out_valid, out_data
    );
endinterface

// File: rtl/hs_slave.sv
// hs_slave: receiving end of a 4-phase valid/ready handshake in the clk_2
// domain. Synchronises valid_2, captures data_2 into a show-ahead FIFO,
// acknowledges with ready_2 and optionally checks for an incrementing sequence.
module hs_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int CHECK_SEQ   = 1
) (
    input  logic       clk_2,
    input  logic       reset_2,
    hs_slave_if.slave  hs,
    output logic [15:0] rx_count,
    output logic        seq_err,
    output logic [7:0]  err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, ACK} state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic                push, pop, full, empty, valid_s;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;

    // valid_2 synchroniser chain; data_2 is never synchronised
    always_ff @(posedge clk_2) begin
        if (reset_2) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], hs.valid_2};
    end

    assign valid_s = sync_q[SYNC_STAGES-1];

    // full/empty from registered pointers only, so a pop never frees a slot for a same-cycle push
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && hs.out_ready;

    // FSM state and registered acknowledge
    always_ff @(posedge clk_2) begin
        if (reset_2) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // FSM next state: capture once per handshake, release once valid_s is seen low
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_s && !full) begin
                    push    = 1'b1;
                    ready_d = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                ready_d = 1'b1;
                if (!valid_s) begin
                    ready_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign hs.ready_2 = ready_q;

    // FIFO pointers, wrap modulo FIFO_DEPTH with an extra lap bit
    always_ff @(posedge clk_2) begin
        if (reset_2) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // FIFO storage write
    always_ff @(posedge clk_2) begin
        if (push) mem[wr_ptr[AW-1:0]] <= hs.data_2;
    end

    assign hs.out_valid = !empty;
    assign hs.out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // accepted-word counter, wraps naturally
    always_ff @(posedge clk_2) begin
        if (reset_2)   rx_count <= '0;
        else if (push) rx_count <= rx_count + 16'd1;
    end

    generate
        if (CHECK_SEQ != 0) begin : g_seq
            logic              have_first;
            logic [DATA_W-1:0] exp_q;

            // sequence checker: first word only seeds the expectation
            always_ff @(posedge clk_2) begin
                if (reset_2) begin
                    have_first <= 1'b0;
                    exp_q      <= '0;
                    seq_err    <= 1'b0;
                    err_count  <= '0;
                end else begin
                    seq_err <= 1'b0;
                    if (push) begin
                        have_first <= 1'b1;
                        exp_q      <= hs.data_2 + DATA_W'(1);
                        if (have_first && (hs.data_2 != exp_q)) begin
                            seq_err <= 1'b1;
                            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
                        end
                    end
                end
            end
        end else begin : g_noseq
            assign seq_err   = 1'b0;
            assign err_count = '0;
        end
    endgenerate
endmodule

// File: tb/tb_hs_slave.sv
// Self-checking bench for hs_slave (DATA_W=8, SYNC_STAGES=2, FIFO_DEPTH=4).
// Expected output words are queued when sent and compared as the DUT pops them.
module tb_hs_slave;
    logic        clk_2 = 1'b0;
    logic        reset_2;
    logic [15:0] rx_count;
    logic        seq_err;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int seq_pulses = 0;
    logic [7:0] sb [$];

    hs_slave_if #(.DATA_W(8)) hs ();

    hs_slave #(
        .DATA_W(8),
        .SYNC_STAGES(2),
        .FIFO_DEPTH(4),
        .CHECK_SEQ(1)
    ) dut (
        .clk_2(clk_2),
        .reset_2(reset_2),
        .hs(hs.slave),
        .rx_count(rx_count),
        .seq_err(seq_err),
        .err_count(err_count)
    );

    always #5 clk_2 = ~clk_2;

    // scoreboard: every accepted output word must match the oldest word sent
    always @(negedge clk_2) begin
        if (!reset_2 && hs.out_valid === 1'b1 && hs.out_ready === 1'b1) begin
            checks++;
            pops++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: got %02h, no word expected", hs.out_data);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (hs.out_data !== e) begin
                    errors++;
                    $display("FAIL scoreboard_data: got %02h want %02h", hs.out_data, e);
                end
            end
        end
    end

    always @(negedge clk_2) begin
        if (!reset_2 && seq_err === 1'b1) seq_pulses++;
    end

    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset_2      = 1'b1;
        hs.valid_2   = 1'b0;
        hs.data_2    = '0;
        hs.out_ready = 1'b0;
        step();
        step();
        reset_2 = 1'b0;
        sb.delete();
    endtask

    // full 4-phase handshake; ok=0 if either phase exceeds its cycle budget
    task automatic send_word(input logic [7:0] d, output bit ok);
        int unsigned n;
        ok = 1'b1;
        sb.push_back(d);
        hs.data_2  = d;
        hs.valid_2 = 1'b1;
        n = 0;
        while (hs.ready_2 !== 1'b1 && n < 50) begin step(); n++; end
        if (hs.ready_2 !== 1'b1) ok = 1'b0;
        hs.valid_2 = 1'b0;
        n = 0;
        while (hs.ready_2 !== 1'b0 && n < 50) begin step(); n++; end
        if (hs.ready_2 !== 1'b0) ok = 1'b0;
    endtask

    // pop everything; ok=0 if the FIFO never empties
    task automatic drain(output bit ok);
        int unsigned n;
        hs.out_ready = 1'b1;
        n = 0;
        while (hs.out_valid === 1'b1 && n < 40) begin step(); n++; end
        hs.out_ready = 1'b0;
        ok = (hs.out_valid === 1'b0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (hs.ready_2 !== 1'b0)   begin errors++; $display("FAIL reset_ready: got %0b want 0", hs.ready_2); end
        checks++; if (hs.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", hs.out_valid); end
        checks++; if (hs.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %02h want 00", hs.out_data); end
        checks++; if (rx_count !== 16'd0)    begin errors++; $display("FAIL reset_rx_count: got %0d want 0", rx_count); end
        checks++; if (seq_err !== 1'b0)      begin errors++; $display("FAIL reset_seq_err: got %0b want 0", seq_err); end
        checks++; if (err_count !== 8'd0)    begin errors++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        sb.push_back(8'h05);
        hs.data_2  = 8'h05;
        hs.valid_2 = 1'b1;
        step();
        checks++; if (hs.ready_2 !== 1'b0) begin errors++; $display("FAIL basic_ready_e0: got %0b want 0", hs.ready_2); end
        step();
        checks++; if (hs.ready_2 !== 1'b0) begin errors++; $display("FAIL basic_ready_e1: got %0b want 0", hs.ready_2); end
        step();
        checks++; if (hs.ready_2 !== 1'b1)   begin errors++; $display("FAIL basic_ready_e2: got %0b want 1", hs.ready_2); end
        checks++; if (hs.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid: got %0b want 1", hs.out_valid); end
        checks++; if (hs.out_data !== 8'h05) begin errors++; $display("FAIL basic_out_data: got %02h want 05", hs.out_data); end
        checks++; if (rx_count !== 16'd1)    begin errors++; $display("FAIL basic_rx_count: got %0d want 1", rx_count); end
        hs.valid_2 = 1'b0;
        step();
        checks++; if (hs.ready_2 !== 1'b1) begin errors++; $display("FAIL basic_ready_hold: got %0b want 1", hs.ready_2); end
        step();
        step();
        checks++; if (hs.ready_2 !== 1'b0) begin errors++; $display("FAIL basic_ready_drop: got %0b want 0", hs.ready_2); end
        checks++; if (rx_count !== 16'd1)  begin errors++; $display("FAIL basic_no_recapture: got %0d want 1", rx_count); end
        drain(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_drain: got %0b want 1", ok); end
    endtask

    task automatic test_stream();
        bit ok, all_ok;
        int base;
        logic [7:0] words [5];
        words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
        do_reset();
        hs.out_ready = 1'b1;
        base = seq_pulses;
        all_ok = 1'b1;
        foreach (words[i]) begin
            send_word(words[i], ok);
            all_ok &= ok;
        end
        checks++; if (all_ok !== 1'b1)            begin errors++; $display("FAIL stream_handshake: got %0b want 1", all_ok); end
        checks++; if (seq_pulses - base !== 1)    begin errors++; $display("FAIL stream_pulses: got %0d want 1", seq_pulses - base); end
        checks++; if (err_count !== 8'd1)         begin errors++; $display("FAIL stream_err_count: got %0d want 1", err_count); end
        checks++; if (rx_count !== 16'd5)         begin errors++; $display("FAIL stream_rx_count: got %0d want 5", rx_count); end
        // expectation is 07 after 06, so FF mismatches; FF->00 wrap must not
        send_word(8'hFF, ok);
        checks++; if (err_count !== 8'd2)         begin errors++; $display("FAIL stream_ff_err: got %0d want 2", err_count); end
        send_word(8'h00, ok);
        checks++; if (err_count !== 8'd2)         begin errors++; $display("FAIL stream_wrap_err: got %0d want 2", err_count); end
        checks++; if (seq_pulses - base !== 2)    begin errors++; $display("FAIL stream_wrap_pulses: got %0d want 2", seq_pulses - base); end
        drain(ok);
        checks++; if (ok !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL stream_drain: got %0b/%0d want 1/0", ok, sb.size()); end
        hs.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok, all_ok, saw_ready;
        int unsigned n;
        do_reset();
        all_ok = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            send_word(8'(i), ok);
            all_ok &= ok;
        end
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL bp_fill: got %0b want 1", all_ok); end
        sb.push_back(8'h05);
        hs.data_2  = 8'h05;
        hs.valid_2 = 1'b1;
        saw_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (hs.ready_2 !== 1'b0) saw_ready = 1'b1;
        end
        checks++; if (saw_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready_held: got %0b want 0", saw_ready); end
        checks++; if (rx_count !== 16'd4)  begin errors++; $display("FAIL bp_rx_full: got %0d want 4", rx_count); end
        hs.out_ready = 1'b1;
        step();
        hs.out_ready = 1'b0;
        checks++; if (hs.ready_2 !== 1'b0) begin errors++; $display("FAIL bp_no_same_cycle_push: got %0b want 0", hs.ready_2); end
        checks++; if (hs.out_data !== 8'h02) begin errors++; $display("FAIL bp_head_after_pop: got %02h want 02", hs.out_data); end
        step();
        checks++; if (hs.ready_2 !== 1'b1) begin errors++; $display("FAIL bp_push_next: got %0b want 1", hs.ready_2); end
        checks++; if (rx_count !== 16'd5)  begin errors++; $display("FAIL bp_rx_count: got %0d want 5", rx_count); end
        hs.valid_2 = 1'b0;
        n = 0;
        while (hs.ready_2 !== 1'b0 && n < 50) begin step(); n++; end
        drain(ok);
        checks++; if (ok !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL bp_drain: got %0b/%0d want 1/0", ok, sb.size()); end
    endtask

    task automatic test_simul_push_pop();
        bit ok, all_ok;
        int base;
        int unsigned n;
        do_reset();
        send_word(8'h10, ok); all_ok = ok;
        send_word(8'h11, ok); all_ok &= ok;
        checks++; if (all_ok !== 1'b1) begin errors++; $display("FAIL pp_fill: got %0b want 1", all_ok); end
        sb.push_back(8'h12);
        hs.data_2  = 8'h12;
        hs.valid_2 = 1'b1;
        step();
        step();
        hs.out_ready = 1'b1;
        step();
        hs.out_ready = 1'b0;
        checks++; if (hs.ready_2 !== 1'b1)   begin errors++; $display("FAIL pp_capture: got %0b want 1", hs.ready_2); end
        checks++; if (hs.out_data !== 8'h11) begin errors++; $display("FAIL pp_head: got %02h want 11", hs.out_data); end
        checks++; if (rx_count !== 16'd3)    begin errors++; $display("FAIL pp_rx_count: got %0d want 3", rx_count); end
        hs.valid_2 = 1'b0;
        n = 0;
        while (hs.ready_2 !== 1'b0 && n < 50) begin step(); n++; end
        base = pops;
        drain(ok);
        checks++; if (pops - base !== 2 || ok !== 1'b1) begin errors++; $display("FAIL pp_occupancy: got %0d want 2", pops - base); end
    endtask

    task automatic test_reset_in_ack();
        bit ok;
        int unsigned n;
        do_reset();
        hs.data_2  = 8'h33;
        hs.valid_2 = 1'b1;
        n = 0;
        while (hs.ready_2 !== 1'b1 && n < 50) begin step(); n++; end
        checks++; if (hs.ready_2 !== 1'b1) begin errors++; $display("FAIL rst_ack_reached: got %0b want 1", hs.ready_2); end
        reset_2 = 1'b1;
        step();
        checks++; if (hs.ready_2 !== 1'b0)   begin errors++; $display("FAIL rst_ack_ready: got %0b want 0", hs.ready_2); end
        checks++; if (hs.out_valid !== 1'b0) begin errors++; $display("FAIL rst_ack_out_valid: got %0b want 0", hs.out_valid); end
        checks++; if (rx_count !== 16'd0)    begin errors++; $display("FAIL rst_ack_rx_count: got %0d want 0", rx_count); end
        reset_2 = 1'b0;
        sb.delete();
        sb.push_back(8'h33);
        step();
        step();
        checks++; if (hs.ready_2 !== 1'b0) begin errors++; $display("FAIL rst_recap_early: got %0b want 0", hs.ready_2); end
        step();
        checks++; if (hs.ready_2 !== 1'b1)   begin errors++; $display("FAIL rst_recap_ready: got %0b want 1", hs.ready_2); end
        checks++; if (rx_count !== 16'd1)    begin errors++; $display("FAIL rst_recap_rx: got %0d want 1", rx_count); end
        checks++; if (hs.out_data !== 8'h33) begin errors++; $display("FAIL rst_recap_data: got %02h want 33", hs.out_data); end
        hs.valid_2 = 1'b0;
        n = 0;
        while (hs.ready_2 !== 1'b0 && n < 50) begin step(); n++; end
        drain(ok);
        checks++; if (ok !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL rst_drain: got %0b/%0d want 1/0", ok, sb.size()); end
    endtask

    task automatic test_saturation();
        bit ok, all_ok;
        do_reset();
        hs.out_ready = 1'b1;
        all_ok = 1'b1;
        // constant 00 words: first seeds expectation 01, every later one mismatches
        for (int i = 0; i < 300; i++) begin
            send_word(8'h00, ok);
            all_ok &= ok;
            if (i == 99) begin
                checks++; if (err_count !== 8'd99) begin errors++; $display("FAIL sat_mid: got %0d want 99", err_count); end
            end
        end
        checks++; if (all_ok !== 1'b1)      begin errors++; $display("FAIL sat_handshake: got %0b want 1", all_ok); end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL sat_err_count: got %0d want 255", err_count); end
        checks++; if (rx_count !== 16'd300) begin errors++; $display("FAIL sat_rx_count: got %0d want 300", rx_count); end
        drain(ok);
        checks++; if (ok !== 1'b1 || sb.size() != 0) begin errors++; $display("FAIL sat_drain: got %0b/%0d want 1/0", ok, sb.size()); end
    endtask

    initial begin
        reset_2      = 1'b1;
        hs.valid_2   = 1'b0;
        hs.data_2    = '0;
        hs.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stream();
        test_backpressure();
        test_simul_push_pop();
        test_reset_in_ack();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
